// File: rtl/holding_register_bank.sv
// holding_register_bank
// A bank of DEPTH holding registers with one write port, two combinational
// read ports, a carry/borrow flag and a shadow bank for save, restore and swap.
// Registers not targeted by a write keep their value, so the datapath needs
// no per-register hold/load muxes.

module holding_register_bank #(
  parameter int WIDTH = 16,
  parameter int AW    = 3,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    wsel,
  input  logic [1:0]       wmode,
  input  logic [WIDTH-1:0] sbus,
  input  logic             save,
  input  logic             restore,
  input  logic [AW-1:0]    ra_sel,
  input  logic [AW-1:0]    rb_sel,
  output logic [WIDTH-1:0] ra_data,
  output logic [WIDTH-1:0] rb_data,
  output logic             carry
);

  typedef enum logic [1:0] {
    MODE_LOAD = 2'b00,
    MODE_INC  = 2'b01,
    MODE_DEC  = 2'b10,
    MODE_CLR  = 2'b11
  } wmode_t;

  logic [WIDTH-1:0] bank   [DEPTH];
  logic [WIDTH-1:0] shadow [DEPTH];

  logic             hit;
  logic             accept;
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] nxt;
  logic             nxt_carry;

  // Find the write target; selects at or above DEPTH match nothing, so such
  // writes fall through as no-ops without an explicit range compare.
  always_comb begin
    hit = 1'b0;
    cur = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (wsel == AW'(i)) begin
        hit = 1'b1;
        cur = bank[i];
      end
    end
  end

  // Next value and carry for the targeted register, modulo 2**WIDTH.
  always_comb begin
    nxt       = cur;
    nxt_carry = 1'b0;
    case (wmode_t'(wmode))
      MODE_LOAD: nxt = sbus;
      MODE_INC: begin
        nxt       = cur + WIDTH'(1);
        nxt_carry = (cur == '1);
      end
      MODE_DEC: begin
        nxt       = cur - WIDTH'(1);
        nxt_carry = (cur == '0);
      end
      MODE_CLR: nxt = '0;
    endcase
  end

  // A restore (alone or as part of a swap) takes priority over the write port.
  assign accept = we && hit && !restore;

  // Bank, shadow and carry state; save copies pre-write values, swap exchanges.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        bank[i]   <= '0;
        shadow[i] <= '0;
      end
      carry <= 1'b0;
    end else if (save && restore) begin
      for (int i = 0; i < DEPTH; i++) begin
        bank[i]   <= shadow[i];
        shadow[i] <= bank[i];
      end
    end else if (restore) begin
      for (int i = 0; i < DEPTH; i++) begin
        bank[i] <= shadow[i];
      end
    end else begin
      if (save) begin
        for (int i = 0; i < DEPTH; i++) begin
          shadow[i] <= bank[i];
        end
      end
      if (accept) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (wsel == AW'(i)) begin
            bank[i] <= nxt;
          end
        end
        carry <= nxt_carry;
      end
    end
  end

  // Combinational read ports; unpopulated addresses read as zero.
  always_comb begin
    ra_data = '0;
    rb_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ra_sel == AW'(i)) ra_data = bank[i];
      if (rb_sel == AW'(i)) rb_data = bank[i];
    end
  end

endmodule

// File: tb/tb_holding_register_bank.sv
// tb_holding_register_bank
// Directed test of holding_register_bank. Two instances share all inputs: a
// full DEPTH=8 bank and a DEPTH=6 bank that exercises out-of-range selects.
// Stimulus pushes expected output values into a queue; a monitor drains the
// queue on every falling edge and compares against the live outputs.

module tb_holding_register_bank;

  localparam int WIDTH = 16;
  localparam int AW    = 3;

  localparam logic [1:0] LOAD = 2'b00;
  localparam logic [1:0] INC  = 2'b01;
  localparam logic [1:0] DEC  = 2'b10;
  localparam logic [1:0] CLR  = 2'b11;

  // Which output an expectation refers to.
  localparam int K_RA   = 0;
  localparam int K_RB   = 1;
  localparam int K_C    = 2;
  localparam int K_RA6  = 3;
  localparam int K_RB6  = 4;
  localparam int K_C6   = 5;

  logic             clk;
  logic             rst;
  logic             we;
  logic [AW-1:0]    wsel;
  logic [1:0]       wmode;
  logic [WIDTH-1:0] sbus;
  logic             save;
  logic             restore;
  logic [AW-1:0]    ra_sel;
  logic [AW-1:0]    rb_sel;
  logic [WIDTH-1:0] ra_data;
  logic [WIDTH-1:0] rb_data;
  logic             carry;
  logic [WIDTH-1:0] ra_data6;
  logic [WIDTH-1:0] rb_data6;
  logic             carry6;

  typedef struct {
    string            name;
    int               kind;
    logic [WIDTH-1:0] exp;
  } expect_t;

  expect_t sb[$];
  int      nChecks;
  int      nErrors;

  holding_register_bank #(.WIDTH(WIDTH), .AW(AW), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .we(we), .wsel(wsel), .wmode(wmode), .sbus(sbus),
    .save(save), .restore(restore), .ra_sel(ra_sel), .rb_sel(rb_sel),
    .ra_data(ra_data), .rb_data(rb_data), .carry(carry)
  );

  holding_register_bank #(.WIDTH(WIDTH), .AW(AW), .DEPTH(6)) dut6 (
    .clk(clk), .rst(rst), .we(we), .wsel(wsel), .wmode(wmode), .sbus(sbus),
    .save(save), .restore(restore), .ra_sel(ra_sel), .rb_sel(rb_sel),
    .ra_data(ra_data6), .rb_data(rb_data6), .carry(carry6)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: on every falling edge compare all queued expectations.
  initial begin
    nChecks = 0;
    nErrors = 0;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        expect_t e;
        logic [WIDTH-1:0] act;
        e = sb.pop_front();
        case (e.kind)
          K_RA:    act = ra_data;
          K_RB:    act = rb_data;
          K_C:     act = {{(WIDTH-1){1'b0}}, carry};
          K_RA6:   act = ra_data6;
          K_RB6:   act = rb_data6;
          default: act = {{(WIDTH-1){1'b0}}, carry6};
        endcase
        nChecks++;
        if (act !== e.exp) begin
          nErrors++;
          $display("[TB] FAIL %s: got 0x%04h expected 0x%04h", e.name, act, e.exp);
        end
      end
    end
  end

  // Drive every input for the coming clock edge.
  task automatic applyStimulus(input logic r, input logic w, input logic [AW-1:0] ws,
                               input logic [1:0] wm, input logic [WIDTH-1:0] sb_v,
                               input logic sv, input logic rs,
                               input logic [AW-1:0] ras, input logic [AW-1:0] rbs);
    rst     = r;
    we      = w;
    wsel    = ws;
    wmode   = wm;
    sbus    = sb_v;
    save    = sv;
    restore = rs;
    ra_sel  = ras;
    rb_sel  = rbs;
  endtask

  // Queue an expected output value for the current cycle.
  task automatic checkOutput(input string name, input int kind, input logic [WIDTH-1:0] exp);
    expect_t e;
    e.name = name;
    e.kind = kind;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Idle cycle with only the read selects driven.
  task automatic idle(input logic [AW-1:0] ras, input logic [AW-1:0] rbs);
    applyStimulus(1'b0, 1'b0, '0, LOAD, 16'h0000, 1'b0, 1'b0, ras, rbs);
  endtask

  initial begin
    // Reset holds even while a load is requested.
    applyStimulus(1'b1, 1'b1, 3'd0, LOAD, 16'hBEEF, 1'b0, 1'b0, 3'd0, 3'd0);
    step();
    applyStimulus(1'b1, 1'b1, 3'd0, LOAD, 16'hBEEF, 1'b0, 1'b0, 3'd0, 3'd0);
    checkOutput("rst_load_r0", K_RA, 16'h0000);
    checkOutput("rst_carry", K_C, 16'h0000);
    step();

    // Reset sweep of both ports over every select value.
    for (int i = 0; i < 8; i++) begin
      idle(AW'(i), AW'(7 - i));
      checkOutput($sformatf("rst_ra%0d", i), K_RA, 16'h0000);
      checkOutput($sformatf("rst_rb%0d", 7 - i), K_RB, 16'h0000);
      checkOutput($sformatf("rst6_ra%0d", i), K_RA6, 16'h0000);
      step();
    end

    // Load r3; same-cycle read shows the old value, then it holds.
    applyStimulus(1'b0, 1'b1, 3'd3, LOAD, 16'h1234, 1'b0, 1'b0, 3'd3, 3'd3);
    checkOutput("load_r3_no_bypass", K_RA, 16'h0000);
    step();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 3'd3, LOAD, (i % 2 == 0) ? 16'h5555 : 16'hAAAA,
                    1'b0, 1'b0, 3'd3, 3'd0);
      checkOutput($sformatf("hold_r3_c%0d", i), K_RA, 16'h1234);
      step();
    end

    // Carry behaviour on r1.
    applyStimulus(1'b0, 1'b1, 3'd1, LOAD, 16'hFFFF, 1'b0, 1'b0, 3'd1, 3'd1);
    step();
    applyStimulus(1'b0, 1'b1, 3'd1, INC, 16'h0000, 1'b0, 1'b0, 3'd1, 3'd1);
    checkOutput("r1_ffff", K_RA, 16'hFFFF);
    checkOutput("carry_before_inc", K_C, 16'h0000);
    step();
    applyStimulus(1'b0, 1'b1, 3'd1, DEC, 16'h0000, 1'b0, 1'b0, 3'd1, 3'd1);
    checkOutput("inc_wrap_val", K_RA, 16'h0000);
    checkOutput("inc_wrap_carry", K_C, 16'h0001);
    step();
    applyStimulus(1'b0, 1'b1, 3'd1, INC, 16'h0000, 1'b0, 1'b0, 3'd1, 3'd1);
    checkOutput("dec_borrow_val", K_RA, 16'hFFFF);
    checkOutput("dec_borrow_carry", K_C, 16'h0001);
    step();
    applyStimulus(1'b0, 1'b1, 3'd1, LOAD, 16'h0042, 1'b0, 1'b0, 3'd1, 3'd1);
    checkOutput("inc_wrap2_val", K_RA, 16'h0000);
    checkOutput("inc_wrap2_carry", K_C, 16'h0001);
    step();
    applyStimulus(1'b0, 1'b1, 3'd1, CLR, 16'h0000, 1'b0, 1'b0, 3'd1, 3'd1);
    checkOutput("load_val", K_RA, 16'h0042);
    checkOutput("load_clears_carry", K_C, 16'h0000);
    step();
    applyStimulus(1'b0, 1'b1, 3'd1, DEC, 16'h0000, 1'b0, 1'b0, 3'd1, 3'd1);
    checkOutput("clr_val", K_RA, 16'h0000);
    step();
    idle(3'd1, 3'd1);
    checkOutput("dec0_val", K_RA, 16'hFFFF);
    checkOutput("dec0_carry", K_C, 16'h0001);
    step();
    applyStimulus(1'b0, 1'b1, 3'd3, CLR, 16'h0000, 1'b0, 1'b0, 3'd3, 3'd1);
    checkOutput("idle_keeps_carry", K_C, 16'h0001);
    step();
    idle(3'd3, 3'd1);
    checkOutput("clr_r3_val", K_RA, 16'h0000);
    checkOutput("clr_clears_carry", K_C, 16'h0000);
    step();

    // Save with a same-cycle write, then restore drops its write.
    applyStimulus(1'b0, 1'b1, 3'd0, LOAD, 16'h00AA, 1'b0, 1'b0, 3'd0, 3'd0);
    step();
    applyStimulus(1'b0, 1'b1, 3'd0, LOAD, 16'h0055, 1'b1, 1'b0, 3'd0, 3'd0);
    checkOutput("r0_before_save", K_RA, 16'h00AA);
    step();
    applyStimulus(1'b0, 1'b1, 3'd0, LOAD, 16'h7777, 1'b0, 1'b1, 3'd0, 3'd1);
    checkOutput("save_write_live", K_RA, 16'h0055);
    step();
    idle(3'd0, 3'd1);
    checkOutput("restore_r0", K_RA, 16'h00AA);
    checkOutput("restore_r1", K_RB, 16'hFFFF);
    step();

    // Swap twice: r2 1111 <-> shadow 2222, with a dropped same-cycle write.
    applyStimulus(1'b0, 1'b1, 3'd2, LOAD, 16'h2222, 1'b0, 1'b0, 3'd2, 3'd2);
    step();
    applyStimulus(1'b0, 1'b0, 3'd2, LOAD, 16'h0000, 1'b1, 1'b0, 3'd2, 3'd2);
    step();
    applyStimulus(1'b0, 1'b1, 3'd2, LOAD, 16'h1111, 1'b0, 1'b0, 3'd2, 3'd2);
    step();
    applyStimulus(1'b0, 1'b1, 3'd2, LOAD, 16'hDEAD, 1'b1, 1'b1, 3'd2, 3'd2);
    checkOutput("pre_swap_r2", K_RA, 16'h1111);
    step();
    applyStimulus(1'b0, 1'b0, 3'd2, LOAD, 16'h0000, 1'b1, 1'b1, 3'd2, 3'd2);
    checkOutput("swap1_r2", K_RA, 16'h2222);
    step();
    idle(3'd2, 3'd0);
    checkOutput("swap2_r2", K_RA, 16'h1111);
    checkOutput("swap2_r0", K_RB, 16'h00AA);
    step();

    // Out-of-range write on the DEPTH=6 bank; in range for the DEPTH=8 bank.
    applyStimulus(1'b0, 1'b1, 3'd6, LOAD, 16'hCAFE, 1'b0, 1'b0, 3'd6, 3'd7);
    step();
    idle(3'd6, 3'd7);
    checkOutput("d8_r6_loaded", K_RA, 16'hCAFE);
    checkOutput("d6_sel6_zero", K_RA6, 16'h0000);
    checkOutput("d6_sel7_zero", K_RB6, 16'h0000);
    checkOutput("d6_carry_kept", K_C6, 16'h0000);
    step();
    idle(3'd0, 3'd1);
    checkOutput("d6_r0", K_RA6, 16'h00AA);
    checkOutput("d6_r1", K_RB6, 16'hFFFF);
    step();
    idle(3'd2, 3'd3);
    checkOutput("d6_r2", K_RA6, 16'h1111);
    checkOutput("d6_r3", K_RB6, 16'h0000);
    step();
    idle(3'd4, 3'd5);
    checkOutput("d6_r4", K_RA6, 16'h0000);
    checkOutput("d6_r5", K_RB6, 16'h0000);
    step();

    // Reset between save and restore clears the shadow bank too.
    applyStimulus(1'b0, 1'b0, 3'd0, LOAD, 16'h0000, 1'b1, 1'b0, 3'd0, 3'd2);
    step();
    applyStimulus(1'b1, 1'b0, 3'd0, LOAD, 16'h0000, 1'b0, 1'b0, 3'd0, 3'd2);
    step();
    applyStimulus(1'b0, 1'b0, 3'd0, LOAD, 16'h0000, 1'b0, 1'b1, 3'd0, 3'd2);
    step();
    idle(3'd0, 3'd6);
    checkOutput("rst_shadow_r0", K_RA, 16'h0000);
    checkOutput("rst_shadow_r6", K_RB, 16'h0000);
    step();
    idle(3'd2, 3'd1);
    checkOutput("rst_shadow_r2", K_RA, 16'h0000);
    checkOutput("rst_shadow_r1", K_RB, 16'h0000);
    step();

    // Let the monitor drain the last expectations.
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      nErrors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule

// File: doc/holding_register_bank.md
# holding_register_bank

Parametrised bank of DEPTH holding registers, each WIDTH bits, that replaces per-register hold/load muxing in the datapath. Each cycle one register can be loaded from the S-bus, incremented, decremented or cleared; all other registers hold their value. The bank also provides two combinational read ports, a one-cycle carry/borrow flag, and a shadow copy of the whole bank with single-cycle save, restore and swap. It sits between the S-bus and the ALU operand selectors in the transfer datapath.

## Interface
- WIDTH, 16, data width of every register
- AW, 3, address width
- DEPTH, 8, number of registers; must satisfy 1 ≤ DEPTH ≤ 2**AW
- clk  in  1  rising-edge clock, the only clock
- rst  in  1  reset, synchronous and active-high
- we  in  1  write enable for the selected register
- wsel  in  AW  register to write
- wmode  in  2  operation: 00 load sbus, 01 increment, 10 decrement, 11 clear
- sbus  in  WIDTH  S-bus data for a load
- save  in  1  copy the bank into the shadow bank
- restore  in  1  copy the shadow bank into the bank
- ra_sel  in  AW  read port A select
- rb_sel  in  AW  read port B select
- ra_data  out  WIDTH  read port A data, combinational
- rb_data  out  WIDTH  read port B data, combinational
- carry  out  1  registered; set when the last accepted INC wrapped or the last accepted DEC borrowed

## Operation
- Reset: when rst=1 at a rising edge, all DEPTH registers, all shadow registers and carry go to 0. rst overrides all other inputs.
- Hold: a register that is not targeted by an accepted write, and is not affected by a restore, keeps its value.
- Write accepted when: we=1, wsel<DEPTH and restore=0.
  - If wsel≥DEPTH, the write is ignored and no state changes.
- Write modes, with all arithmetic modulo 2**WIDTH:
  - LOAD: reg ← sbus.
  - INC: reg ← reg+1. carry ← 1 if reg was all-ones, else 0.
  - DEC: reg ← reg−1. carry ← 1 if reg was 0, else 0.
  - CLR: reg ← 0.
- carry update rules:
  - LOAD and CLR clear carry.
  - carry is unchanged in any cycle with no accepted write.
- save=1, restore=0: shadow[i] ← reg[i] for all i. The shadow captures the values from before any same-cycle write.
  - The same-cycle write still updates the live register.
- restore=1, save=0: reg[i] ← shadow[i] for all i. Any same-cycle write is dropped, and carry is unchanged.
- save=1 and restore=1: swap. The bank and the shadow bank exchange contents in one cycle. Any same-cycle write is dropped.
- Read ports:
  - ra_data = reg[ra_sel] and rb_data = reg[rb_sel], taken from current register state.
  - A select ≥ DEPTH reads 0.
  - A write is visible on the read ports only after the clock edge; there is no write-to-read bypass.

## Timing
- Write latency is 1 cycle: the new value appears on the read ports just after the edge that sampled we=1.
- carry changes on the same edge as the write that sets or clears it.
- save, restore and swap each complete in a single cycle. Back-to-back operations on consecutive cycles are legal.
- Read ports have 0 cycles of latency: the path from a select input to its data output is purely combinational.
- When rst is asserted in the middle of a sequence (for example between a save and a restore), the shadow bank is also cleared. A restore in the following cycle therefore yields all zeros.
- Outputs after reset:
  - ra_data = 0 and rb_data = 0, for any select value.
  - carry = 0.

## Test plan
- Reset, then sweep ra_sel and rb_sel over 0..2**AW−1 → both ports read 0x0000 and carry=0. Assert rst with we=1, LOAD, sbus=0xBEEF → the register stays 0.
- LOAD 0x1234 into r3, then we=0 for 5 cycles with sbus toggling → ra_sel=3 reads 0x1234 throughout. Reading r3 in the same cycle as the load shows the old value 0x0000.
- LOAD 0xFFFF into r1, then INC r1 → r1=0x0000, carry=1. DEC r1 → r1=0xFFFF, carry=1. INC r1 → r1=0x0000, carry=1. LOAD r1 → carry=0.
- r0=0x00AA, then save together with LOAD r0=0x0055 → live r0=0x0055. Next cycle restore with we=1 LOAD r0=0x7777 → r0=0x00AA (write dropped).
- r2=0x1111 and shadow r2=0x2222, then save and restore together → r2=0x2222. Next cycle swap again → r2=0x1111.
- With DEPTH=6 and AW=3, issue a write to wsel=6 with LOAD 0xCAFE → no register changes. ra_sel=7 reads 0x0000.
